int_gateway: RTL
================

# int_gateway

Per-source interrupt gateway for the sangcore interrupt controller, placed directly upstream of the pending-register array. It turns raw level or edge interrupt inputs into one held `gate` request per source. While a request is in flight it blocks further requests from that source until software signals completion. Edge sources queue up to 2^CNT_W−1 unserviced edges.

## Interface
- NSRC, 8, number of interrupt sources (1..32)
- CNT_W, 3, width of the per-source pending-edge counter (≥1)

- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- irq_src  input  NSRC  raw interrupt lines, active-high, may be asynchronous when INT_GW_SYNC_EN is defined
- irq_edge_mode  input  NSRC  per source: 1 = edge-triggered, 0 = level-triggered
- claim  input  NSRC  one-hot, one-cycle pulse: source claimed by the hart
- complete  input  NSRC  one-hot, one-cycle pulse: handler for source finished
- gate  output  NSRC  registered request to the pending register; held high until claimed or retracted
- ovf  output  NSRC  sticky flag: an edge was dropped because the counter was saturated

## Operation
- `s[i]` is the sampled source: the output of the synchronizer when it is enabled, otherwise `irq_src[i]`. `s_prev[i]` is `s[i]` delayed one cycle. `rise = s & ~s_prev`.
- Each source runs its own FSM with states IDLE, REQ and BUSY. `gate[i]` is registered and equals (state == REQ).
- Level mode:
  - IDLE→REQ when `s` = 1.
  - REQ→IDLE when `s` = 0 and there is no claim. This retracts the request.
  - REQ→BUSY on claim. Claim has priority over retraction in the same cycle.
  - BUSY→IDLE on complete.
- Edge mode, counter `cnt`:
  - Update rule: `cnt_next = cnt + rise − (claim accepted in REQ)`, saturating at 2^CNT_W−1.
  - Saturation: a rise arriving while `cnt` is at max with no claim leaves `cnt` unchanged and sets `ovf[i]`.
  - IDLE→REQ when `cnt` ≠ 0 or `rise` = 1.
  - REQ→BUSY on claim. The request is never retracted.
  - BUSY→IDLE on complete. If `cnt` ≠ 0, the FSM re-enters REQ one cycle later, so `gate` is low for at least one cycle.
- Stray pulses are ignored with no state change: claim in IDLE or BUSY; complete in IDLE or REQ.
- Mode change: `irq_edge_mode` is registered as `mode_q`. When `irq_edge_mode[i]` ≠ `mode_q[i]`, source i is forced to IDLE, `cnt` is cleared, and `mode_q` takes the new value. `ovf` is not cleared.
- Sources are fully independent. Bits of claim or complete for other sources never affect source i.

## Timing
- Reset values: gate = 0, ovf = 0, every FSM in IDLE, cnt = 0, s_prev = 0, synchronizer flops = 0, mode_q = 0.
- Request latency, from the first clock edge at which `irq_src` is seen high to `gate` high:
  - 1 cycle without INT_GW_SYNC_EN.
  - 3 cycles with INT_GW_SYNC_EN.
- Claim at edge N: `gate` is low after edge N.
- Complete at edge N with `cnt` ≠ 0 (edge mode): `gate` is high again after edge N+1.
- Level retraction: `s` low at edge N deasserts `gate` after edge N.
- Reset may arrive mid-operation (REQ or BUSY). It returns everything to reset values immediately, and in-flight claim or complete pulses are lost.

## Configuration
- INT_GW_SYNC_EN:
  - Defined: a two-flop synchronizer is inserted on every `irq_src` bit, adding 2 cycles of request latency. Use this for asynchronous sources.
  - Not defined: `irq_src` feeds the edge detector and FSM directly. Sources must then be synchronous to `clk`.

## Test plan
All latencies below are given with INT_GW_SYNC_EN off.
- **Level request, claim, complete:** mode 0, raise irq_src[0] at cycle 0 → gate[0] = 1 at cycle 1. Claim[0] at cycle 4 → gate[0] = 0 at cycle 5. Complete[0] at cycle 8 with src still high → gate[0] = 1 at cycle 10.
- **Level retraction:** mode 0, src[1] high for cycles 0–2 with no claim → gate[1] high for cycles 1–3, then 0, FSM in IDLE.
- **Edge queuing:** mode 1, three rising edges on src[2] before any claim → cnt = 3. Then run three claim/complete pairs, each complete followed by gate low for 1 cycle and then high. After the third complete, gate stays 0 and cnt = 0.
- **Saturation:** CNT_W = 3, nine edges on src[3] with no claim → cnt = 7, ovf[3] = 1 and stays 1 after the counter drains.
- **Simultaneous events:** rise and claim on the same cycle in edge mode → cnt unchanged. A complete to a source in REQ, or a claim to a source in IDLE → no change.
- **Reset and mode change:** assert rst while source 4 is in BUSY with cnt = 2 → gate = 0, cnt = 0, ovf = 0 immediately. Toggling mode on a source in REQ → gate drops next cycle and cnt = 0.

Source files
------------

// File: rtl/int_gateway.sv
// int_gateway: per-source interrupt gateway ahead of the pending-register array.
// Each source turns a raw level or edge interrupt into one held `gate` request
// and blocks further requests until the handler signals completion. Edge
// sources count queued edges up to 2^CNT_W-1 and flag drops in sticky `ovf`.
//
// Optional feature macro: INT_GW_SYNC_EN
//   defined     -> two-flop synchronizer on every irq_src bit (+2 cycles latency)
//   not defined -> irq_src feeds the edge detector and FSMs directly
//
// Handshake: claim and complete are one-hot, one-cycle pulses. A claim is
// accepted only by a source in REQ and a complete only by a source in BUSY;
// pulses arriving in any other state are ignored. gate stays high from REQ
// entry until a claim is accepted (or, in level mode, the source retracts).
//
// Debug outputs: dbg_state packs each source's FSM (IDLE=0, REQ=1, BUSY=2)
// in 2-bit fields; dbg_cnt packs each source's pending-edge counter.
module int_gateway #(
   parameter int NSRC  = 8,
   parameter int CNT_W = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NSRC-1:0]         irq_src,
   input  logic [NSRC-1:0]         irq_edge_mode,
   input  logic [NSRC-1:0]         claim,
   input  logic [NSRC-1:0]         complete,
   output logic [NSRC-1:0]         gate,
   output logic [NSRC-1:0]         ovf,
   output logic [2*NSRC-1:0]       dbg_state,
   output logic [NSRC*CNT_W-1:0]   dbg_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_BUSY = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q [NSRC];
   state_e           state_d [NSRC];
   logic [CNT_W-1:0] cnt_q   [NSRC];
   logic [CNT_W-1:0] cnt_d   [NSRC];
   logic [NSRC-1:0]  mode_q;
   logic [NSRC-1:0]  s_prev_q;
   logic [NSRC-1:0]  ovf_q;
   logic [NSRC-1:0]  ovf_d;
   logic [NSRC-1:0]  s;
   logic [NSRC-1:0]  rise;
   logic [NSRC-1:0]  claim_acc;

`ifdef INT_GW_SYNC_EN
   logic [NSRC-1:0] sync1_q;
   logic [NSRC-1:0] sync2_q;

   // Two-flop synchronizer for sources asynchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_src;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   assign s = irq_src;
`endif

   assign rise = s & ~s_prev_q;

   // A claim only counts against a source that is currently requesting.
   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         claim_acc[i] = (state_q[i] == ST_REQ) && claim[i];
      end
   end

   // Next-state, counter and overflow logic for every source.
   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         ovf_d[i]   = ovf_q[i];

         if (irq_edge_mode[i] != mode_q[i]) begin
            // Mode switch: drop any in-flight request and queued edges.
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
         end else if (mode_q[i]) begin
            // Edge mode: a rise and an accepted claim in the same cycle cancel.
            if (rise[i] && !claim_acc[i]) begin
               if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
               else                     cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!rise[i] && claim_acc[i] && (cnt_q[i] != '0)) begin
               cnt_d[i] = cnt_q[i] - 1'b1;
            end

            case (state_q[i])
               ST_IDLE: if ((cnt_q[i] != '0) || rise[i]) state_d[i] = ST_REQ;
               ST_REQ:  if (claim[i])                    state_d[i] = ST_BUSY;
               ST_BUSY: if (complete[i])                 state_d[i] = ST_IDLE;
               default:                                  state_d[i] = ST_IDLE;
            endcase
         end else begin
            // Level mode: request follows the line until claimed.
            case (state_q[i])
               ST_IDLE: if (s[i]) state_d[i] = ST_REQ;
               ST_REQ: begin
                  if (claim[i])  state_d[i] = ST_BUSY;
                  else if (!s[i]) state_d[i] = ST_IDLE;
               end
               ST_BUSY: if (complete[i]) state_d[i] = ST_IDLE;
               default:                  state_d[i] = ST_IDLE;
            endcase
         end
      end
   end

   // State registers for all sources.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q   <= '0;
         s_prev_q <= '0;
         ovf_q    <= '0;
         for (int i = 0; i < NSRC; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         mode_q   <= irq_edge_mode;
         s_prev_q <= s;
         ovf_q    <= ovf_d;
         for (int i = 0; i < NSRC; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // gate is decoded straight from the state register, so it is glitch-free.
   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         gate[i]                      = (state_q[i] == ST_REQ);
         dbg_state[2*i +: 2]          = state_q[i];
         dbg_cnt[i*CNT_W +: CNT_W]    = cnt_q[i];
      end
   end

   assign ovf = ovf_q;

endmodule
